// File: rtl/i2c_target_responder.sv
// I2C target: START/STOP decode, 7-bit address match, write bytes out on rx_*, read bytes in from tx_*.
// Latency: pins to scl_s/sda_s 2 cycles (4 with I2C_TARGET_GLITCH_FILTER_EN); sda_o moves 1 cycle after the conditioned SCL fall.
// Backpressure: none on rx (every write byte is ACKed); an empty tx stream substitutes UNDERRUN_BYTE.
module i2c_target_responder #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h12,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       underrun_o
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_DATA   = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_RD_DATA   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    logic scl_m, scl_q, sda_m, sda_q;
    logic scl_s, sda_s, scl_d, sda_d;

    // Synchronizers reset to the idle-bus level so reset release never looks like a bus event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_m <= 1'b1;
            scl_q <= 1'b1;
            sda_m <= 1'b1;
            sda_q <= 1'b1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= scl_i;
            scl_q <= scl_m;
            sda_m <= sda_i;
            sda_q <= sda_m;
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
        end else begin
            scl_h <= {scl_h[0], scl_q};
            sda_h <= {sda_h[0], sda_q};
        end
    end

    // Follow the input only once three consecutive samples agree; otherwise hold the last level.
    assign scl_s = (scl_q == scl_h[0] && scl_h[0] == scl_h[1]) ? scl_q : scl_d;
    assign sda_s = (sda_q == sda_h[0] && sda_h[0] == sda_h[1]) ? sda_q : sda_d;
`else
    assign scl_s = scl_q;
    assign sda_s = sda_q;
`endif

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] load_byte;

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign load_byte = tx_valid_i ? tx_data_i : UNDERRUN_BYTE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'd0;
            sda_o      <= 1'b1;
            rx_data_o  <= 8'd0;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            underrun_o <= 1'b0;
            // Bus events override whatever byte is in flight; a partial byte is simply dropped.
            if (start_det) begin
                start_o <= 1'b1;
                bit_cnt <= 4'd0;
                sda_o   <= 1'b1;
                busy_o  <= 1'b0;
                state   <= ST_ADDR;
            end else if (stop_det) begin
                stop_o <= 1'b1;
                sda_o  <= 1'b1;
                busy_o <= 1'b0;
                state  <= ST_IDLE;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_reg[7:1] == SLAVE_ADDR) begin
                                sda_o  <= 1'b0;
                                busy_o <= 1'b1;
                                state  <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // shift_reg[0] still holds the R/W bit of the address byte.
                        if (scl_fall) begin
                            if (!shift_reg[0]) begin
                                sda_o   <= 1'b1;
                                bit_cnt <= 4'd0;
                                state   <= ST_WR_DATA;
                            end else begin
                                sda_o      <= load_byte[7];
                                shift_reg  <= {load_byte[6:0], 1'b0};
                                bit_cnt    <= 4'd1;
                                tx_ready_o <= tx_valid_i;
                                underrun_o <= ~tx_valid_i;
                                state      <= ST_RD_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data_o  <= {shift_reg[6:0], sda_s};
                                rx_valid_o <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_o <= 1'b0;
                            state <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_o   <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        // bit_cnt counts bits already placed on the bus.
                        if (scl_fall) begin
                            if (bit_cnt < 4'd8) begin
                                sda_o     <= shift_reg[7];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 4'd1;
                            end else begin
                                sda_o <= 1'b1;
                                state <= ST_RD_ACK;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && sda_s) begin
                            busy_o <= 1'b0;
                            state  <= ST_WAIT_STOP;
                        end else if (scl_fall) begin
                            sda_o      <= load_byte[7];
                            shift_reg  <= {load_byte[6:0], 1'b0};
                            bit_cnt    <= 4'd1;
                            tx_ready_o <= tx_valid_i;
                            underrun_o <= ~tx_valid_i;
                            state      <= ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/i2c_target_responder.md
# i2c_target_responder

Synthesizable I2C target (slave) that answers the I2C multi-bus controller on one bus. It is the bus-level responder counterpart to the controller's master sequencer. It decodes START, STOP and repeated START, matches a 7-bit address and acknowledges it, then either delivers write bytes on a streaming output or serves read bytes from a streaming input. It sits on the `scl`/`sda` open-drain nets beside the controller, is clocked by the system clock, and oversamples the bus.

## Interface
- `SLAVE_ADDR`, 7'h12: 7-bit target address; address byte 0x24 = write, 0x25 = read.
- `UNDERRUN_BYTE`, 8'hFF: byte transmitted when no read data is available.
- `clk_i`  in  1  system clock; one clock domain only.
- `rst_i`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  I2C clock input (asynchronous to `clk_i`).
- `sda_i`  in  1  I2C data input (asynchronous to `clk_i`).
- `sda_o`  out  1  open-drain data drive: 0 pulls low, 1 releases. Reset 1.
- `rx_data_o`  out  8  last received write byte. Reset 0.
- `rx_valid_o`  out  1  one-cycle pulse; `rx_data_o` is valid. Reset 0.
- `tx_data_i`  in  8  next read byte.
- `tx_valid_i`  in  1  `tx_data_i` is available.
- `tx_ready_o`  out  1  one-cycle pulse; `tx_data_i` was loaded into the shifter. Reset 0.
- `start_o`  out  1  pulse on START or repeated START. Reset 0.
- `stop_o`  out  1  pulse on STOP. Reset 0.
- `busy_o`  out  1  high while addressed (from address ACK to STOP/START/NACK). Reset 0.
- `underrun_o`  out  1  pulse when `UNDERRUN_BYTE` is substituted. Reset 0.

## Operation
- Input conditioning: `scl_i` and `sda_i` each pass through a 2-flop synchronizer, giving `scl_s`/`sda_s`. Edge detects compare `scl_s`/`sda_s` against their value one cycle earlier.
- Bus events (checked in every state, highest priority):
  - START: `sda_s` falls while `scl_s` = 1. Pulse `start_o`, clear the bit counter, release `sda_o`, go to ADDR.
  - STOP: `sda_s` rises while `scl_s` = 1. Pulse `stop_o`, release `sda_o`, go to IDLE, drop `busy_o`.
- States:
  - IDLE: wait for START.
  - ADDR: shift in one bit, MSB first, on each `scl_s` rising edge. After 8 bits, compare bits [7:1] with `SLAVE_ADDR`.
    - Match: on the next `scl` falling edge drive `sda_o` = 0, raise `busy_o`, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP with `sda_o` released.
  - ADDR_ACK: on the falling edge that ends the ACK slot:
    - R/W = 0: release `sda_o`, go to WR_DATA.
    - R/W = 1: load the read byte, drive its MSB, go to RD_DATA.
  - WR_DATA: shift in 8 bits on `scl` rising edges. On the 8th bit, `rx_data_o` updates and `rx_valid_o` pulses in the same cycle. On the next falling edge drive ACK (0), go to WR_ACK.
  - WR_ACK: on the falling edge, release `sda_o`, return to WR_DATA.
  - RD_DATA: on each `scl` falling edge drive the next bit. After bit 0 has been clocked out, release `sda_o` at the falling edge and go to RD_ACK.
  - RD_ACK: sample `sda_s` on the `scl` rising edge.
    - 0 (ACK): at the next falling edge load a new byte, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP, drop `busy_o`.
  - WAIT_STOP: `sda_o` stays released; ignore all bits until START or STOP.
- Byte load: if `tx_valid_i` = 1, shift `tx_data_i` in and pulse `tx_ready_o`. Otherwise shift `UNDERRUN_BYTE` in and pulse `underrun_o`.
- Write bytes are always ACKed; there is no backpressure on `rx_*`. General call and 10-bit addressing are not supported; both are treated as an address mismatch.

## Timing
- Requirement: `clk_i` ≥ 10× SCL frequency.
- Conditioning latency from pin to `scl_s`/`sda_s`: 2 cycles (4 with the filter).
- `sda_o` changes exactly 1 `clk_i` cycle after the conditioned `scl` falling edge is detected. It never changes while `scl_s` = 1, except for reset and the forced release on START/STOP.
- `rx_valid_o`, `tx_ready_o`, `underrun_o`, `start_o` and `stop_o` are single-cycle pulses, registered, and never asserted during reset.
- START and STOP detected in the same cycle as a data edge: the bus event wins and the partial byte is discarded (no `rx_valid_o`).
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous reset) and the state returns to IDLE. Bus traffic is ignored until the next START.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN`
  - Defined: a 3-sample filter follows each synchronizer. `scl_s`/`sda_s` change only when 3 consecutive samples agree, adding 2 cycles of latency and rejecting pulses shorter than 3 cycles.
  - Undefined: synchronizer only, and a 1-cycle glitch propagates.
  - All other behaviour is identical in both builds.

## Test plan
- Write 0x24 then 0x00..0x07 then STOP: ACK (`sda` = 0) in all 9 ACK slots; 8 `rx_valid_o` pulses carrying 0x00..0x07; one `start_o`, one `stop_o`; `busy_o` = 0 after STOP.
- Read 0x25 with `tx_data_i` stream 0x08..0x0F, master ACKs 7 bytes and NACKs the 8th: bus carries 0x08..0x0F; 8 `tx_ready_o` pulses; `sda_o` = 1 after the NACK; no `underrun_o`.
- Address byte 0x26: `sda` stays 1 in the 9th slot; subsequent bytes produce no `rx_valid_o`; `stop_o` still pulses.
- Write 0x24, 0x05, repeated START, read 0x25 with NACK, `tx_data_i` = 0x08: `start_o` pulses twice, `rx_data_o` = 0x05, bus read returns 0x08.
- Read 0x25 with `tx_valid_i` = 0: 0xFF is transmitted, `underrun_o` pulses once, `tx_ready_o` stays 0.
- Assert `rst_i` while `sda_o` = 0 during an ACK slot: `sda_o` = 1 in the same cycle, no pulses. After release, data bytes are ignored until a new START, followed by a correct 0x24 write.
